// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file for the RISC-V datapath.
//
// Register 0 reads as zero. Register EXT_IN_REG reads the live ext_in value and
// ignores writes. Register OUT_REG is mirrored on out_reg. After every reset a
// sequential clear engine zeroes registers 1..DEPTH-1 one per cycle. While the
// clear runs, writes are ignored and reads return zero. ready then rises.
//
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, a read whose
// address matches an enabled write port in the same cycle (RUN only) returns
// that port's wr_data combinationally.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   rst      in   synchronous active-high reset (restarts the clear)
//   rd_addr  in   NUM_READ*ADDRESS_WIDTH packed read addresses (port i = slice i)
//   rd_data  out  NUM_READ*DATA_WIDTH packed read data (port i = slice i)
//   wr_en    in   NUM_WRITE per-port write enables
//   wr_addr  in   NUM_WRITE*ADDRESS_WIDTH packed write addresses
//   wr_data  in   NUM_WRITE*DATA_WIDTH packed write data
//   ext_in   in   live value presented as register EXT_IN_REG
//   out_reg  out  stored value of register OUT_REG
//   ready    out  high once the clear is complete and writes are accepted
module regfile_mp #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned NUM_READ      = 2,
  parameter int unsigned NUM_WRITE     = 2,
  parameter int unsigned EXT_IN_REG    = 31,
  parameter int unsigned OUT_REG       = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  input  logic [NUM_WRITE-1:0]              wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH-1:0]             ext_in,
  output logic [DATA_WIDTH-1:0]             out_reg,
  output logic                              ready
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] EXT_ADDR = ADDRESS_WIDTH'(EXT_IN_REG);
  localparam logic [ADDRESS_WIDTH-1:0] OUT_ADDR = ADDRESS_WIDTH'(OUT_REG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clr_idx;
  logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

  logic [ADDRESS_WIDTH-1:0] ra;
`ifdef REGFILE_BYPASS_EN
  logic [ADDRESS_WIDTH-1:0] bwa;
`endif

  // Clear engine and write ports share one process. The write loop runs in
  // port order, so the last NBA to an address comes from the highest enabled
  // port and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= ADDRESS_WIDTH'(1);
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_idx] <= '0;
          // Leave on the last index instead of incrementing, so clr_idx never wraps.
          if (clr_idx == '1) begin
            state <= RUN;
          end else begin
            clr_idx <= clr_idx + ADDRESS_WIDTH'(1);
          end
        end
        RUN: begin
          for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wr_en[j] &&
                (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0) &&
                (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != EXT_ADDR)) begin
              mem[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <=
                wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      endcase
    end
  end

  assign ready = (state == RUN);

  // Storage is read only in RUN. Stale or uninitialised contents therefore
  // never reach the outputs while the clear is still running.
  always_comb begin
    rd_data = '0;
    ra      = '0;
`ifdef REGFILE_BYPASS_EN
    bwa     = '0;
`endif
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      ra = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (ra == '0) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (ra == EXT_ADDR) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = ext_in;
      end else if (state == RUN) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
          bwa = wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          if (wr_en[j] && (bwa == ra)) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
`endif
      end
    end
  end

  // The mirror output is never bypassed.
  always_comb begin
    if (OUT_ADDR == '0) begin
      out_reg = '0;
    end else if (OUT_ADDR == EXT_ADDR) begin
      out_reg = ext_in;
    end else if (state == RUN) begin
      out_reg = mem[OUT_ADDR];
    end else begin
      out_reg = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] ext_in;
  logic [31:0] out_reg;
  logic        ready;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp #(
    .DATA_WIDTH(32),
    .ADDRESS_WIDTH(5),
    .NUM_READ(2),
    .NUM_WRITE(2),
    .EXT_IN_REG(31),
    .OUT_REG(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .ext_in(ext_in),
    .out_reg(out_reg),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Called in the cycle right after a reset edge. Counts the cycles with
  // ready low, with a bounded wait.
  task automatic wait_ready(input string tag);
    int cnt;
    check({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (ready === 1'b1) break;
      cnt++;
    end
    check({tag, "_len"}, cnt, 32'd31);
    check({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; ext_in = '0;
    step();
    rst = 1'b0;

    // Reads during the first clear.
    rd_addr = {5'd0, 5'd31}; ext_in = 32'h0000_5A5A; #1;
    check("clr_ext_rd", rd_data[31:0], 32'h0000_5A5A);
    check("clr_x0_rd", rd_data[63:32], 32'h0);
    rd_addr = {5'd10, 5'd1}; #1;
    check("clr_x1_rd", rd_data[31:0], 32'h0);
    check("clr_out_reg", out_reg, 32'h0);

    // These writes are held through the whole clear. They must be ignored.
    wr_en = 2'b11; wr_addr = {5'd3, 5'd2}; wr_data = {32'hBAD3_0003, 32'hBAD2_0002};
    wait_ready("clr1");
    wr_en = '0;
    for (int a = 1; a <= 30; a++) begin
      rd_addr = {5'(a), 5'(a)}; #1;
      check($sformatf("zero_p0_x%0d", a), rd_data[31:0], 32'h0);
      check($sformatf("zero_p1_x%0d", a), rd_data[63:32], 32'h0);
    end
    check("run_out_reg0", out_reg, 32'h0);

    // Basic write/read.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF};
    step(); wr_en = '0;
    rd_addr = {5'd0, 5'd5}; #1;
    check("wr_x5", rd_data[31:0], 32'hDEAD_BEEF);
    wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0000_1234, 32'h0};
    step(); wr_en = '0;
    rd_addr = {5'd0, 5'd0}; #1;
    check("wr_x0", rd_data[63:32], 32'h0);

    // Write conflict, then two writes to distinct addresses.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    step(); wr_en = '0;
    rd_addr = {5'd7, 5'd7}; #1;
    check("conflict_x7", rd_data[31:0], 32'h22);
    wr_en = 2'b11; wr_addr = {5'd9, 5'd8}; wr_data = {32'h44, 32'h33};
    step(); wr_en = '0;
    rd_addr = {5'd9, 5'd8}; #1;
    check("dual_x8", rd_data[31:0], 32'h33);
    check("dual_x9", rd_data[63:32], 32'h44);

    // Hardwired registers.
    ext_in = 32'h0000_0001;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd31}; wr_data = {32'h0, 32'hFF};
    step(); wr_en = '0;
    rd_addr = {5'd0, 5'd31}; #1;
    check("ext_x31", rd_data[31:0], 32'h1);
    ext_in = 32'hCAFE_F00D; #1;
    check("ext_track", rd_data[31:0], 32'hCAFE_F00D);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h0000_ABCD}; #1;
    check("out_reg_pre", out_reg, 32'h0);
    step(); wr_en = '0; #1;
    check("out_reg_post", out_reg, 32'h0000_ABCD);

    // Same-cycle write/read of one address.
    rd_addr = {5'd3, 5'd3};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55}; #1;
    check("byp_x3", rd_data[31:0], BYP ? 32'h55 : 32'h0);
    step(); wr_en = '0; #1;
    check("byp_x3_next", rd_data[31:0], 32'h55);
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h77, 32'h66}; #1;
    check("byp_prio", rd_data[63:32], BYP ? 32'h77 : 32'h55);
    step(); wr_en = '0; #1;
    check("byp_prio_next", rd_data[31:0], 32'h77);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd31}; wr_data = {32'h0, 32'h1111};
    rd_addr = {5'd0, 5'd31}; #1;
    check("byp_ext_none", rd_data[31:0], 32'hCAFE_F00D);
    step(); wr_en = '0;

    // Reset mid-run, then a second reset partway through the clear.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h99};
    step(); wr_en = '0;
    rd_addr = {5'd0, 5'd4}; #1;
    check("x4_pre_rst", rd_data[31:0], 32'h99);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_ready", {31'd0, ready}, 32'd0);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h77}; #1;
    check("x4_clr", rd_data[31:0], 32'h0);
    check("out_reg_clr", out_reg, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("x4_clr_c%0d", k), rd_data[31:0], 32'h0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("clr3");
    wr_en = '0; #1;
    check("x4_after", rd_data[31:0], 32'h0);
    check("out_reg_after", out_reg, 32'h0);
    rd_addr = {5'd7, 5'd5}; #1;
    check("x5_after", rd_data[31:0], 32'h0);
    check("x7_after", rd_data[63:32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
